memory_access_controller: RTL and testbench

MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

---
 rtl/memory_access_controller.sv | 108 ++++++++++
 tb/tb_memory_access_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_controller.sv
// rtl/memory_access_controller.sv - host-to-8x8-memory access sequencer with clear sweep
module memory_access_controller #(
    parameter logic [7:0] CLR_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       clr_start,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       clr_done,
    output logic       mem_op,
    output logic       mem_select,
    output logic [2:0] mem_address,
    output logic [7:0] mem_in_bus,
    input  logic [7:0] mem_out_bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0] state;
    logic       sweep;
    logic [2:0] sweep_cnt;

    // Strobe decoded from state so an async reset drops it without a clock edge.
    assign mem_select = (state == STROBE);
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign req_ready  = rst_n && (state == IDLE) && !clr_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sweep       <= 1'b0;
            sweep_cnt   <= 3'd0;
            mem_op      <= 1'b0;
            mem_address <= 3'd0;
            mem_in_bus  <= 8'h00;
            rsp_data    <= 8'h00;
            clr_done    <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        sweep       <= 1'b1;
                        sweep_cnt   <= 3'd0;
                        mem_op      <= 1'b1;
                        mem_address <= 3'd0;
                        mem_in_bus  <= CLR_VALUE;
                        state       <= SETUP;
                    end else if (req_valid) begin
                        sweep       <= 1'b0;
                        mem_op      <= req_write;
                        mem_address <= req_addr;
                        mem_in_bus  <= req_wdata;
                        if (req_write) begin
                            rsp_data <= req_wdata;
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                end
                STROBE: begin
                    if (!mem_op) begin
                        rsp_data <= mem_out_bus;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (!sweep) begin
                        state <= RESP;
                    end else if (sweep_cnt == 3'd7) begin
                        // Counter parks at 7; the next sweep reloads it.
                        sweep    <= 1'b0;
                        clr_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        sweep_cnt   <= sweep_cnt + 3'd1;
                        mem_address <= sweep_cnt + 3'd1;
                        state       <= SETUP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
// tb/tb_memory_access_controller.sv - directed plus randomized bench with memory model and bus monitor
module tb_memory_access_controller;

    localparam logic [7:0] CLR = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       clr_start;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       busy, clr_done;
    logic       mem_op, mem_select;
    logic [2:0] mem_address;
    logic [7:0] mem_in_bus, mem_out_bus;

    int checks = 0;
    int failures = 0;
    int exp_access = 0;
    int sel_cnt = 0;

    logic [7:0] mem [8];
    logic [7:0] ref_mem [8];

    memory_access_controller #(.CLR_VALUE(CLR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .clr_start(clr_start),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .clr_done(clr_done),
        .mem_op(mem_op), .mem_select(mem_select), .mem_address(mem_address),
        .mem_in_bus(mem_in_bus), .mem_out_bus(mem_out_bus)
    );

    always #5 clk = ~clk;

    // Downstream 8x8 memory unit.
    always @(posedge clk) begin
        if (mem_select && mem_op) mem[mem_address] <= mem_in_bus;
    end
    assign mem_out_bus = mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic        prev_sel = 1'b0;
    logic [11:0] prev_bus = 12'h0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_select) begin
                chk("mon_sel_width", {31'd0, prev_sel}, 0);
                chk("mon_setup_stable", {mem_op, mem_address, mem_in_bus}, prev_bus);
                sel_cnt++;
            end
            if (prev_sel) begin
                chk("mon_sel_drop", {31'd0, mem_select}, 0);
                chk("mon_hold_stable", {mem_op, mem_address, mem_in_bus}, prev_bus);
            end
            prev_sel = mem_select;
            prev_bus = {mem_op, mem_address, mem_in_bus};
        end else begin
            prev_sel = 1'b0;
        end
    end

    // Runs from just after the handshake edge to the first IDLE cycle after the response.
    task automatic finish_req(input bit w, input logic [2:0] a, input logic [7:0] d,
                              input int hold, input bit clr_mid);
        logic [7:0] exp;
        int n;
        exp = w ? d : ref_mem[a];
        exp_access++;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            if (clr_mid && n == 1) clr_start = 1'b1;
            @(negedge clk);
            clr_start = 1'b0;
            n++;
        end
        chk("rsp_latency", n, 3);
        chk("rsp_data", rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 1);
            chk("hold_rsp_data", rsp_data, exp);
            chk("hold_req_ready", {31'd0, req_ready}, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (w) ref_mem[a] = d;
        @(negedge clk);
        chk("idle_after_rsp", {31'd0, busy}, 0);
        chk("no_clr_done_after_rsp", {31'd0, clr_done}, 0);
    endtask

    task automatic do_req(input bit w, input logic [2:0] a, input logic [7:0] d,
                          input int hold, input bit clr_mid);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'd0, n < 40}, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        finish_req(w, a, d, hold, clr_mid);
    endtask

    task automatic do_sweep(input bit with_req, input logic [2:0] a, input logic [7:0] d);
        int busy_n, done_n, rsp_n;
        @(negedge clk);
        clr_start = 1'b1;
        if (with_req) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        end
        #1 chk("ready_low_with_clr", {31'd0, req_ready}, 0);
        @(posedge clk);
        #1 clr_start = 1'b0;
        exp_access += 8;
        busy_n = 0; done_n = 0; rsp_n = 0;
        @(negedge clk);
        while (busy && busy_n < 40) begin
            busy_n++;
            if (clr_done) done_n++;
            if (rsp_valid) rsp_n++;
            @(negedge clk);
        end
        chk("sweep_busy_cycles", busy_n, 24);
        chk("sweep_clr_done", {31'd0, clr_done}, 1);
        chk("sweep_done_while_busy", done_n, 0);
        chk("sweep_no_rsp", rsp_n, 0);
        for (int i = 0; i < 8; i++) ref_mem[i] = CLR;
        if (with_req) begin
            chk("pending_req_ready", {31'd0, req_ready}, 1);
            @(posedge clk);
            #1 req_valid = 1'b0;
            finish_req(1'b1, a, d, 0, 1'b0);
        end else begin
            @(negedge clk);
            chk("clr_done_one_cycle", {31'd0, clr_done}, 0);
        end
    endtask

    task automatic reset_mid_strobe(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        chk("pre_reset_ready", {31'd0, req_ready}, 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 chk("strobe_before_reset", {31'd0, mem_select}, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_sel_async", {31'd0, mem_select}, 0);
        chk("reset_outputs", {mem_op, mem_address, mem_in_bus, rsp_valid, rsp_data, busy, clr_done, req_ready}, 0);
        @(negedge clk);
        chk("reset_no_rsp", {31'd0, rsp_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", {31'd0, req_ready}, 1);
        chk("post_reset_busy", {31'd0, busy}, 0);
        ref_mem[a] = 8'hxx;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd0;
        req_wdata = 8'h00; clr_start = 1'b0; rsp_ready = 1'b0;
        #3;
        chk("reset_state", {mem_op, mem_select, mem_address, mem_in_bus, rsp_valid, rsp_data, busy, clr_done, req_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1 chk("first_idle_ready", {31'd0, req_ready}, 1);

        do_req(1'b1, 3'd3, 8'hA5, 0, 1'b0);
        do_req(1'b0, 3'd3, 8'h00, 0, 1'b0);
        do_req(1'b0, 3'd3, 8'h00, 6, 1'b0);

        for (int i = 0; i < 8; i++) do_req(1'b1, 3'(i), 8'hFF, 0, 1'b0);
        do_sweep(1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) do_req(1'b0, 3'(i), 8'h00, 0, 1'b0);

        do_sweep(1'b1, 3'd5, 8'h3C);
        do_req(1'b0, 3'd5, 8'h00, 0, 1'b0);

        do_req(1'b1, 3'd6, 8'h96, 1, 1'b1);
        do_req(1'b0, 3'd6, 8'h00, 0, 1'b1);

        reset_mid_strobe(3'd2, 8'h77);
        do_req(1'b1, 3'd2, 8'h11, 0, 1'b0);
        do_req(1'b0, 3'd2, 8'h00, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_sweep(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            end else begin
                do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
        end

        chk("strobe_count", sel_cnt, exp_access);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
